// File: rtl/demux_8_32bit_reg.sv
// Registered 1-to-8 demultiplexer: steers one input word per handshake into one of
// eight single-entry holding slots (or all of them on broadcast), each draining by valid/ready.
module demux_8_32bit_reg #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_ch,
    input  logic               in_bcast,
    input  logic [WIDTH-1:0]   in_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [15:0]        acc_cnt
);

    // Same 3-to-8 truth table as the companion select mux.
    function automatic logic [7:0] decode_3to8(input logic [2:0] sel);
        logic [7:0] onehot;
        case (sel)
            3'd0:    onehot = 8'b0000_0001;
            3'd1:    onehot = 8'b0000_0010;
            3'd2:    onehot = 8'b0000_0100;
            3'd3:    onehot = 8'b0000_1000;
            3'd4:    onehot = 8'b0001_0000;
            3'd5:    onehot = 8'b0010_0000;
            3'd6:    onehot = 8'b0100_0000;
            default: onehot = 8'b1000_0000;
        endcase
        return onehot;
    endfunction

    logic [7:0]       r_full;
    logic [WIDTH-1:0] r_data [8];
    logic [15:0]      r_acc_cnt;

    logic [7:0]       w_target;
    logic [7:0]       w_free;
    logic [7:0]       w_pop;
    logic [7:0]       w_write;
    logic             w_accept;

    assign w_target = in_bcast ? 8'hFF : decode_3to8(in_ch);
    assign w_pop    = r_full & out_ready;
    // A draining slot counts as free, so it can be refilled on the same edge.
    assign w_free   = ~r_full | out_ready;

    // Broadcast needs every slot free at once; it is never partially written.
    assign in_ready = in_bcast ? (&w_free) : w_free[in_ch];
    assign w_accept = in_valid & in_ready;
    assign w_write  = w_accept ? w_target : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_write[i]) begin
                    r_full[i] <= 1'b1;
                end else if (w_pop[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Data is held (not cleared) on pop; only reset zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_write[i]) begin
                    r_data[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_cnt <= 16'h0000;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 16'h0001;
        end
    end

    assign out_valid = r_full;
    assign acc_cnt   = r_acc_cnt;

    for (genvar g = 0; g < 8; g++) begin : g_slice
        assign out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

endmodule
